// File: rtl/spi_transmit.sv
// Dual-channel SPI transmitter for the PmodDA2 (two DAC121S101). Shifts one 16-bit
// frame per channel, MSB first, on two data lines sharing sclk and sync_n.
module spi_transmit #(
  parameter int HALF_PERIOD = 2,
  parameter int SYNC_GAP    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] data1,
  input  logic [11:0] data2,
  input  logic [1:0]  pd,
  output logic        sdata1,
  output logic        sdata2,
  output logic        sclk,
  output logic        sync_n,
  output logic        done
);

  localparam int DIV_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int GAP_LEN = 2 * HALF_PERIOD * SYNC_GAP;
  localparam int GAP_W   = $clog2(GAP_LEN);

  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(HALF_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(GAP_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [15:0]      sh1_r;
  logic [15:0]      sh2_r;
  logic             sclk_r;
  logic             sync_n_r;
  logic             done_r;

  logic [15:0]      frame1_s;
  logic [15:0]      frame2_s;
  logic             div_tc_s;
  logic             gap_tc_s;
  logic             load_s;

  // Frame assembly and load decision; a start still held at the end of the gap
  // chains straight into the next frame so the sync_n gap is exactly GAP_LEN.
  always_comb begin
    frame1_s = {2'b00, pd, data1};
    frame2_s = {2'b00, pd, data2};
    div_tc_s = (div_cnt_r == DIV_TC);
    gap_tc_s = (gap_cnt_r == GAP_TC);
    load_s   = 1'b0;
    case (state_r)
      IDLE:    load_s = start;
      GAP:     load_s = start & gap_tc_s;
      default: load_s = 1'b0;
    endcase
  end

  // Frame sequencer, sclk divider and the two output shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      div_cnt_r <= '0;
      bit_cnt_r <= 4'd0;
      gap_cnt_r <= '0;
      sh1_r     <= 16'd0;
      sh2_r     <= 16'd0;
      sclk_r    <= 1'b1;
      sync_n_r  <= 1'b1;
      done_r    <= 1'b1;
    end else if (load_s) begin
      state_r   <= SHIFT;
      div_cnt_r <= '0;
      bit_cnt_r <= 4'd0;
      gap_cnt_r <= '0;
      sh1_r     <= frame1_s;
      sh2_r     <= frame2_s;
      sclk_r    <= 1'b1;
      sync_n_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sclk_r   <= 1'b1;
          sync_n_r <= 1'b1;
          done_r   <= 1'b1;
        end
        SHIFT: begin
          if (div_tc_s) begin
            div_cnt_r <= '0;
            sclk_r    <= ~sclk_r;
            if (sclk_r) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (bit_cnt_r == 4'd0) begin
              // bit counter wrapped: this rising edge follows the 16th fall
              state_r   <= GAP;
              gap_cnt_r <= '0;
              sync_n_r  <= 1'b1;
              sh1_r     <= 16'd0;
              sh2_r     <= 16'd0;
            end else begin
              sh1_r <= {sh1_r[14:0], 1'b0};
              sh2_r <= {sh2_r[14:0], 1'b0};
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        GAP: begin
          sclk_r   <= 1'b1;
          sync_n_r <= 1'b1;
          if (gap_tc_s) begin
            state_r   <= IDLE;
            gap_cnt_r <= '0;
            done_r    <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          sclk_r   <= 1'b1;
          sync_n_r <= 1'b1;
          done_r   <= 1'b1;
        end
      endcase
    end
  end

  assign sdata1 = sh1_r[15];
  assign sdata2 = sh2_r[15];
  assign sclk   = sclk_r;
  assign sync_n = sync_n_r;
  assign done   = done_r;

endmodule

// File: tb/tb_spi_transmit.sv
// Randomised self-checking bench for spi_transmit: two instances (H=2/GAP=1 and
// H=1/GAP=2) observed by a behavioural DAC model that samples on sclk falls.
module tb_spi_transmit;

  localparam int H0 = 2;
  localparam int G0 = 1;
  localparam int H1 = 1;
  localparam int G1 = 2;

  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic [11:0] d1 [2];
  logic [11:0] d2 [2];
  logic [1:0]  pd [2];
  logic sdata1 [2];
  logic sdata2 [2];
  logic sclk   [2];
  logic sync_n [2];
  logic done   [2];

  int hp [2];
  int sg [2];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  spi_transmit #(.HALF_PERIOD(H0), .SYNC_GAP(G0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .data1(d1[0]), .data2(d2[0]), .pd(pd[0]),
    .sdata1(sdata1[0]), .sdata2(sdata2[0]), .sclk(sclk[0]), .sync_n(sync_n[0]), .done(done[0]));

  spi_transmit #(.HALF_PERIOD(H1), .SYNC_GAP(G1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .data1(d1[1]), .data2(d2[1]), .pd(pd[1]),
    .sdata1(sdata1[1]), .sdata2(sdata2[1]), .sclk(sclk[1]), .sync_n(sync_n[1]), .done(done[1]));

  // DAC model state: one record per completed frame, kept in a ring of 8
  bit          in_f [2];
  bit          have_prev [2];
  logic        sclk_q [2];
  int          low_c [2];
  int          fall_c [2];
  int          high_c [2];
  int          first_f [2];
  int          nfr [2];
  logic [15:0] w1 [2];
  logic [15:0] w2 [2];
  logic [15:0] cap1 [2][8];
  logic [15:0] cap2 [2][8];
  int          low_rec [2][8];
  int          fall_rec [2][8];
  int          gap_rec [2][8];
  int          ff_rec [2][8];

  // DAC model: shift in sdata on every falling sclk while sync_n is low
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        in_f[i]      = 1'b0;
        have_prev[i] = 1'b0;
        sclk_q[i]    = 1'b1;
      end else begin
        if (!sync_n[i]) begin
          if (!in_f[i]) begin
            in_f[i]   = 1'b1;
            low_c[i]  = 0;
            fall_c[i] = 0;
            first_f[i] = -1;
            w1[i] = 16'd0;
            w2[i] = 16'd0;
            gap_rec[i][nfr[i] % 8] = have_prev[i] ? high_c[i] : -1;
          end
          low_c[i]++;
          if (sclk_q[i] && !sclk[i]) begin
            fall_c[i]++;
            if (first_f[i] < 0) first_f[i] = low_c[i];
            w1[i] = {w1[i][14:0], sdata1[i]};
            w2[i] = {w2[i][14:0], sdata2[i]};
          end
        end else begin
          if (in_f[i]) begin
            in_f[i] = 1'b0;
            cap1[i][nfr[i] % 8]     = w1[i];
            cap2[i][nfr[i] % 8]     = w2[i];
            low_rec[i][nfr[i] % 8]  = low_c[i];
            fall_rec[i][nfr[i] % 8] = fall_c[i];
            ff_rec[i][nfr[i] % 8]   = first_f[i];
            nfr[i]++;
            have_prev[i] = 1'b1;
            high_c[i] = 0;
          end
          high_c[i]++;
        end
        sclk_q[i] = sclk[i];
      end
    end
  end

  function automatic logic [15:0] exp_word(input logic [1:0] p, input logic [11:0] d);
    return 16'(int'(p) * 4096 + int'(d));
  endfunction

  function automatic int exp_lat(input int i);
    return 32 * hp[i] + 2 * hp[i] * sg[i];
  endfunction

  task automatic pulse_frame(input int i, input logic [11:0] a, input logic [11:0] b,
                             input logic [1:0] p, output int lat);
    @(negedge clk);
    d1[i] = a; d2[i] = b; pd[i] = p; start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (done[i]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_sync(input int i, input logic val, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (sync_n[i] === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [4:0] o;
    int base;
    for (int i = 0; i < 2; i++) begin
      o = {sclk[i], sync_n[i], sdata1[i], sdata2[i], done[i]};
      chk_cnt++;
      if (o !== 5'b11001) $display("FAIL reset_power_on[%0d]: got %b expected 11001", i, o);
      else pass_cnt++;
    end
    @(negedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      o = {sclk[i], sync_n[i], sdata1[i], sdata2[i], done[i]};
      chk_cnt++;
      if (o !== 5'b11001) $display("FAIL reset_idle[%0d]: got %b expected 11001", i, o);
      else pass_cnt++;
    end
    @(negedge clk); #2 rst = 1'b0;
    base = nfr[0];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      d1[i] = 12'hFFF; d2[i] = 12'hFFF; pd[i] = 2'b11; start[i] = 1'b1;
    end
    @(posedge clk);
    #1 start[0] = 1'b0; start[1] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk_cnt++;
    if (sync_n[0] !== 1'b0) $display("FAIL reset_preframe: sync_n got %b expected 0", sync_n[0]);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      o = {sclk[i], sync_n[i], sdata1[i], sdata2[i], done[i]};
      chk_cnt++;
      if (o !== 5'b11001) $display("FAIL reset_midframe[%0d]: got %b expected 11001", i, o);
      else pass_cnt++;
    end
    @(negedge clk); #2 rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk_cnt++;
    if (nfr[0] !== base || done[0] !== 1'b1)
      $display("FAIL reset_no_resume: frames %0d done %b expected 0 frames done 1", nfr[0] - base, done[0]);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int lat, li;
    pulse_frame(0, 12'hA5C, 12'h3F0, 2'b00, lat);
    li = (nfr[0] - 1) % 8;
    chk_cnt++;
    if (cap1[0][li] !== 16'h0A5C) $display("FAIL basic_ch1: got %h expected 0a5c", cap1[0][li]);
    else pass_cnt++;
    chk_cnt++;
    if (cap2[0][li] !== 16'h03F0) $display("FAIL basic_ch2: got %h expected 03f0", cap2[0][li]);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== exp_lat(0)) $display("FAIL basic_done: got %0d expected %0d", lat, exp_lat(0));
    else pass_cnt++;
    chk_cnt++;
    if (low_rec[0][li] !== 32 * hp[0]) $display("FAIL basic_sync_low: got %0d expected %0d", low_rec[0][li], 32 * hp[0]);
    else pass_cnt++;
    chk_cnt++;
    if (fall_rec[0][li] !== 16) $display("FAIL basic_falls: got %0d expected 16", fall_rec[0][li]);
    else pass_cnt++;
    chk_cnt++;
    if (ff_rec[0][li] !== hp[0] + 1) $display("FAIL basic_first_fall: got %0d expected %0d", ff_rec[0][li], hp[0] + 1);
    else pass_cnt++;
  endtask

  task automatic test_pd;
    int lat, li;
    pulse_frame(0, 12'h000, 12'hFFF, 2'b11, lat);
    li = (nfr[0] - 1) % 8;
    chk_cnt++;
    if (cap1[0][li] !== 16'h3000 || cap2[0][li] !== 16'h3FFF)
      $display("FAIL pd_frames: got %h/%h expected 3000/3fff", cap1[0][li], cap2[0][li]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int base, n;
    bit ok, all_ok;
    logic [11:0] r2;
    base = nfr[0];
    all_ok = 1'b1;
    r2 = 12'($urandom);
    @(negedge clk);
    d1[0] = 12'd1; d2[0] = r2; pd[0] = 2'b01; start[0] = 1'b1;
    for (int k = 2; k <= 3; k++) begin
      wait_sync(0, 1'b0, ok); all_ok &= ok;
      d1[0] = 12'(k);
      wait_sync(0, 1'b1, ok); all_ok &= ok;
    end
    wait_sync(0, 1'b0, ok); all_ok &= ok;
    start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    all_ok &= done[0];
    chk_cnt++;
    if (!all_ok) $display("FAIL b2b_timeout: got ok=%b expected ok=1", all_ok);
    else pass_cnt++;
    chk_cnt++;
    if (nfr[0] - base !== 3) $display("FAIL b2b_count: got %0d expected 3", nfr[0] - base);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (cap1[0][(base + k) % 8] !== exp_word(2'b01, 12'(k + 1)) || cap2[0][(base + k) % 8] !== exp_word(2'b01, r2))
        $display("FAIL b2b_frame%0d: got %h/%h expected %h/%h", k, cap1[0][(base + k) % 8],
                 cap2[0][(base + k) % 8], exp_word(2'b01, 12'(k + 1)), exp_word(2'b01, r2));
      else pass_cnt++;
    end
    for (int k = 1; k < 3; k++) begin
      chk_cnt++;
      if (gap_rec[0][(base + k) % 8] !== 2 * hp[0] * sg[0])
        $display("FAIL b2b_gap%0d: got %0d expected %0d", k, gap_rec[0][(base + k) % 8], 2 * hp[0] * sg[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_input_change;
    int base, lat, n, li;
    base = nfr[0];
    @(negedge clk);
    d1[0] = 12'h123; d2[0] = 12'h456; pd[0] = 2'b00; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 d1[0] = 12'hFFF; pd[0] = 2'b10; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    li = base % 8;
    chk_cnt++;
    if (nfr[0] - base !== 1 || cap1[0][li] !== 16'h0123 || cap2[0][li] !== 16'h0456)
      $display("FAIL chg_ignored: got %0d frames %h/%h expected 1 frames 0123/0456", nfr[0] - base, cap1[0][li], cap2[0][li]);
    else pass_cnt++;
    pulse_frame(0, 12'hFFF, 12'h456, 2'b00, lat);
    li = (nfr[0] - 1) % 8;
    chk_cnt++;
    if (cap1[0][li] !== 16'h0FFF) $display("FAIL chg_next: got %h expected 0fff", cap1[0][li]);
    else pass_cnt++;
  endtask

  task automatic test_fast;
    int lat, li;
    pulse_frame(1, 12'h800, 12'h001, 2'b00, lat);
    li = (nfr[1] - 1) % 8;
    chk_cnt++;
    if (cap1[1][li] !== 16'h0800 || cap2[1][li] !== 16'h0001)
      $display("FAIL fast_frames: got %h/%h expected 0800/0001", cap1[1][li], cap2[1][li]);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== exp_lat(1)) $display("FAIL fast_done: got %0d expected %0d", lat, exp_lat(1));
    else pass_cnt++;
    chk_cnt++;
    if (low_rec[1][li] !== 32 || fall_rec[1][li] !== 16 || ff_rec[1][li] !== 2)
      $display("FAIL fast_timing: got low %0d falls %0d first %0d expected 32 16 2",
               low_rec[1][li], fall_rec[1][li], ff_rec[1][li]);
    else pass_cnt++;
  endtask

  task automatic test_random;
    int lat, li, i;
    logic [11:0] a, b;
    logic [1:0] p;
    for (int t = 0; t < 10; t++) begin
      i = t % 2;
      a = 12'($urandom);
      b = 12'($urandom);
      p = 2'($urandom_range(3, 0));
      pulse_frame(i, a, b, p, lat);
      li = (nfr[i] - 1) % 8;
      chk_cnt++;
      if (cap1[i][li] !== exp_word(p, a) || cap2[i][li] !== exp_word(p, b) || lat !== exp_lat(i))
        $display("FAIL random%0d: got %h/%h lat %0d expected %h/%h lat %0d", t, cap1[i][li], cap2[i][li],
                 lat, exp_word(p, a), exp_word(p, b), exp_lat(i));
      else pass_cnt++;
    end
  endtask

  initial begin
    hp[0] = H0; sg[0] = G0;
    hp[1] = H1; sg[1] = G1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; d1[i] = 12'd0; d2[i] = 12'd0; pd[i] = 2'b00;
    end
    #12;
    test_reset();
    test_basic();
    test_pd();
    test_back_to_back();
    test_input_change();
    test_fast();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
